// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared FSM state encoding and default operand width for seq_divider
package seq_divider_pkg;
  localparam int DEFAULT_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/seq_divider_step.sv
// div_step: one restoring-division iteration on a WIDTH+1-bit partial remainder
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic             q
);
  logic [WIDTH:0]   part;
  logic [WIDTH+1:0] diff;
  assign part   = {rem, din};
  assign diff   = {1'b0, part} - {2'b0, divisor};
  assign q      = ~diff[WIDTH+1];
  assign rem_nx = WIDTH'(q ? diff : {1'b0, part});
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative signed/unsigned restoring divider, one quotient bit per cycle
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             sgn, qneg, rneg;
  logic [WIDTH-1:0] rem, dq, dvs, rem_nx, qfin, a_mag, b_mag;
  logic             qbit, accept, zero_in;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid & in_ready;
  assign zero_in   = divisor == '0;
  assign a_mag     = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag     = (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;
  assign qfin      = {dq[WIDTH-2:0], qbit};
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem    (rem),
    .din    (dq[WIDTH-1]),
    .divisor(dvs),
    .rem_nx (rem_nx),
    .q      (qbit)
  );
  always_comb begin
    state_nx = state;
    if (state == IDLE && in_valid) state_nx = zero_in ? DONE : CALC;
    else if (state == CALC && cnt == '0) state_nx = DONE;
    else if (state == DONE && out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // working registers: dq shifts the dividend out as quotient bits shift in
  always_ff @(posedge clk) begin
    if (accept) begin
      sgn  <= is_signed;
      qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg <= dividend[WIDTH-1];
      rem  <= '0;
      dq   <= a_mag;
      dvs  <= b_mag;
      cnt  <= CW'(WIDTH - 1);
    end else if (state == CALC) begin
      rem <= rem_nx;
      dq  <= qfin;
      cnt <= cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && zero_in) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (state == CALC && cnt == '0) begin
      quotient    <= (sgn & qneg) ? -qfin : qfin;
      remainder   <= (sgn & rneg) ? -rem_nx : rem_nx;
      div_by_zero <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic model
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  int checks = 0;
  int failures = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    z = (b == 32'd0);
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    is_signed = ~s;
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (quotient !== 32'd0) begin failures++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    if (remainder !== 32'd0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    logic        vs [9] = '{0, 1, 1, 0, 1, 1, 0, 0, 1};
    logic [31:0] va [9] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    logic [31:0] vb [9] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF,
                            32'd1, 32'hFFFF_FFFF, 32'd9};
    logic [31:0] eq, er;
    logic        ez;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      model(vs[i], va[i], vb[i], eq, er, ez);
      start_op(vs[i], va[i], vb[i]);
      wait_done(lat);
      checks += 4;
      if (lat !== (ez ? 1 : 33)) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, ez ? 1 : 33); end
      if (quotient !== eq) begin failures++; $display("FAIL dir%0d_quotient got=%h exp=%h", i, quotient, eq); end
      if (remainder !== er) begin failures++; $display("FAIL dir%0d_remainder got=%h exp=%h", i, remainder, er); end
      if (div_by_zero !== ez) begin failures++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, div_by_zero, ez); end
      finish_op();
    end
  endtask

  task automatic test_random();
    logic        s, ez;
    logic [31:0] a, b, eq, er;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        2:       b = -$urandom_range(1, 20);
        3:       b = $urandom_range(1, 65535);
        default: b = $urandom;
      endcase
      model(s, a, b, eq, er, ez);
      start_op(s, a, b);
      wait_done(lat);
      checks += 4;
      if (lat !== (ez ? 1 : 33)) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, ez ? 1 : 33); end
      if (quotient !== eq) begin failures++; $display("FAIL rnd%0d_quotient s=%b a=%h b=%h got=%h exp=%h", i, s, a, b, quotient, eq); end
      if (remainder !== er) begin failures++; $display("FAIL rnd%0d_remainder s=%b a=%h b=%h got=%h exp=%h", i, s, a, b, remainder, er); end
      if (div_by_zero !== ez) begin failures++; $display("FAIL rnd%0d_dbz got=%b exp=%b", i, div_by_zero, ez); end
      finish_op();
    end
  endtask

  task automatic test_hold();
    logic [31:0] eq, er;
    logic        ez;
    int          lat;
    model(1'b0, 32'd1000, 32'd7, eq, er, ez);
    start_op(1'b0, 32'd1000, 32'd7);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      dividend = 32'd5;
      divisor  = 32'd0;
      @(negedge clk);
      checks += 5;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL hold%0d_out_valid got=%b exp=1", i, out_valid); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL hold%0d_in_ready got=%b exp=0", i, in_ready); end
      if (quotient !== eq) begin failures++; $display("FAIL hold%0d_quotient got=%h exp=%h", i, quotient, eq); end
      if (remainder !== er) begin failures++; $display("FAIL hold%0d_remainder got=%h exp=%h", i, remainder, er); end
      if (div_by_zero !== 1'b0) begin failures++; $display("FAIL hold%0d_dbz got=%b exp=0", i, div_by_zero); end
    end
    in_valid = 1'b0;
    finish_op();
    checks += 2;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_abort();
    bit seen = 1'b0;
    int lat;
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    if (quotient !== 32'd0) begin failures++; $display("FAIL abort_quotient got=%h exp=0", quotient); end
    if (remainder !== 32'd0) begin failures++; $display("FAIL abort_remainder got=%h exp=0", remainder); end
    if (div_by_zero !== 1'b0) begin failures++; $display("FAIL abort_dbz got=%b exp=0", div_by_zero); end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL abort_stray_out_valid got=1 exp=0"); end
    start_op(1'b0, 32'd9, 32'd3);
    wait_done(lat);
    checks += 3;
    if (lat !== 33) begin failures++; $display("FAIL after_abort_latency got=%0d exp=33", lat); end
    if (quotient !== 32'd3) begin failures++; $display("FAIL after_abort_quotient got=%h exp=3", quotient); end
    if (remainder !== 32'd0) begin failures++; $display("FAIL after_abort_remainder got=%h exp=0", remainder); end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request operands present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 is_signed  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-007 dividend  input  WIDTH  numerator.
REQ-008 divisor  input  WIDTH  denominator.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  WIDTH  result quotient.
REQ-012 remainder  output  WIDTH  result remainder.
REQ-013 div_by_zero  output  1  result was produced from divisor == 0.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 An accept occurs on the edge where in_valid & in_ready; the block SHALL latch is_signed, the operand magnitudes, the quotient/remainder sign flags and the zero flag.
REQ-016 If divisor != 0, IDLE→CALC; CALC SHALL run exactly WIDTH cycles with a restoring algorithm, one quotient bit per cycle, MSB first; the block SHALL then move CALC→DONE, so out_valid rises WIDTH+1 cycles after the accept edge.
REQ-017 Each CALC step SHALL shift {rem,dividend} left by 1, trial-subtract divisor from a WIDTH+1-bit partial remainder, keep the difference and set the quotient bit to 1 if it is non-negative, otherwise restore.
REQ-018 Unsigned mode SHALL give quotient = floor(dividend/divisor) and remainder = dividend - quotient*divisor.
REQ-019 Signed mode SHALL truncate toward zero; the remainder SHALL take the sign of the dividend; signs SHALL be applied by negating the magnitudes on the CALC→DONE transition.
REQ-020 Signed overflow (dividend = most-negative, divisor = -1) SHALL produce quotient = most-negative and remainder = 0 through the normal path; no special case is required beyond correct magnitude arithmetic.
REQ-021 divisor == 0 SHALL skip CALC: IDLE→DONE on the accept edge, with quotient = all ones, remainder = dividend (as given), and div_by_zero = 1; out_valid SHALL rise 1 cycle after accept, in both modes.
REQ-022 DONE SHALL hold quotient, remainder and div_by_zero stable while out_ready = 0; on out_valid & out_ready the block SHALL go DONE→IDLE.
REQ-023 There is no pipelining: in_ready SHALL be 0 from the accept until the cycle after the result handshake; in_valid during CALC or DONE SHALL be ignored.
REQ-024 Outputs in IDLE and CALC SHALL hold their last values; consumers SHALL sample them only when out_valid = 1.

Reset
REQ-025 While rst_n = 0 at a clock edge, the block SHALL enter IDLE with in_ready = 1 and out_valid = 0, and with quotient, remainder and div_by_zero all 0.
REQ-026 Reset asserted during CALC or DONE SHALL abort the operation and discard the result, with no out_valid pulse afterward.
REQ-027 in_ready SHALL read 1 in the first cycle after rst_n deasserts.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, CALC, DONE) and the default WIDTH constant.
REQ-029 A combinational sub-module div_step SHALL hold one restoring iteration: inputs are the partial remainder, the next dividend bit and the divisor; outputs are the next partial remainder and the quotient bit.
REQ-030 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL be loaded with WIDTH-1 on accept.

Verification
REQ-031 Unsigned 100/7, accept at edge T: out_valid at T+33, quotient = 14, remainder = 2, div_by_zero = 0.
REQ-032 Signed -7/2: quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF; also signed 7/-2: quotient = 0xFFFFFFFD, remainder = 1.
REQ-033 5/0 (either mode): out_valid at T+1, quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1.
REQ-034 Signed 0x80000000/0xFFFFFFFF: quotient = 0x80000000, remainder = 0; unsigned 0xFFFFFFFF/1: quotient = 0xFFFFFFFF, remainder = 0.
REQ-035 Hold out_ready = 0 for 10 cycles in DONE: outputs stable, in_ready = 0, and a new in_valid is not accepted; on release the block returns to IDLE the next cycle.
REQ-036 Drive rst_n = 0 at CALC cycle 10: next cycle IDLE, out_valid = 0, outputs 0; a following 9/3 returns quotient = 3, remainder = 0.
